// File: rtl/ha_fa_ripple_adder.sv
// Registered ripple-carry adder built from half-adder and full-adder cells.
// The HA cells supply per-bit generate/propagate; the FA chain produces the
// sum and carries. All results register together with a one-cycle valid flag.

// Half adder: s = x^y, c = x&y.
module ha_cell (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

// Full adder. With ci=0 it reduces exactly to the half adder.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module ha_fa_ripple_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [WIDTH-1:0] gen,
  output logic [WIDTH-1:0] prop
);

  // c[i] is the carry into bit i; c[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] gen_c;
  logic [WIDTH-1:0] prop_c;
  logic             ovf_c;

  assign c[0] = cin;

  // One HA and one FA per bit; carries ripple LSB to MSB with no lookahead.
  ha_cell u_ha [WIDTH-1:0] (
    .x (a),
    .y (b),
    .s (prop_c),
    .c (gen_c)
  );

  fa_cell u_fa [WIDTH-1:0] (
    .x  (a),
    .y  (b),
    .ci (c[WIDTH-1:0]),
    .s  (sum_c),
    .co (c[WIDTH:1])
  );

  // Signed overflow: carry into MSB differs from carry out. For WIDTH=1
  // the carry into the MSB is cin itself.
  assign ovf_c = c[WIDTH] ^ c[WIDTH-1];

  // Valid flag tracks in_valid each cycle; cleared immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_valid <= 1'b0;
    else        out_valid <= in_valid;
  end

  // Result registers load only on valid input and otherwise hold, so
  // garbage on a/b/cin while idle never reaches the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
      gen  <= '0;
      prop <= '0;
    end else if (in_valid) begin
      sum  <= sum_c;
      cout <= c[WIDTH];
      ovf  <= ovf_c;
      gen  <= gen_c;
      prop <= prop_c;
    end
  end

endmodule

// File: tb/tb_ha_fa_ripple_adder.sv
// Directed bench for ha_fa_ripple_adder at WIDTH=1, 4 and 8.
module tb_ha_fa_ripple_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // WIDTH=1 instance
  logic       v1 = 0, a1 = 0, b1 = 0, ci1 = 0;
  logic       ov1, s1, co1, of1, g1, p1;
  // WIDTH=4 instance
  logic       v4 = 0, ci4 = 0;
  logic [3:0] a4 = 0, b4 = 0;
  logic       ov4, co4, of4;
  logic [3:0] s4, g4, p4;
  // WIDTH=8 instance
  logic       v8 = 0, ci8 = 0;
  logic [7:0] a8 = 0, b8 = 0;
  logic       ov8, co8, of8;
  logic [7:0] s8, g8, p8;

  ha_fa_ripple_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .cin(ci1),
    .out_valid(ov1), .sum(s1), .cout(co1), .ovf(of1), .gen(g1), .prop(p1));

  ha_fa_ripple_adder #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .a(a4), .b(b4), .cin(ci4),
    .out_valid(ov4), .sum(s4), .cout(co4), .ovf(of4), .gen(g4), .prop(p4));

  ha_fa_ripple_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .cin(ci8),
    .out_valid(ov8), .sum(s8), .cout(co8), .ovf(of8), .gen(g8), .prop(p8));

  task automatic test_reset();
    #3;
    tests++;
    if ({ov1, s1, co1, of1, g1, p1} !== 6'b0) begin
      fails++; $display("FAIL reset_w1 got %b exp 000000", {ov1, s1, co1, of1, g1, p1});
    end
    tests++;
    if ({ov4, s4, co4, of4, g4, p4} !== 15'b0) begin
      fails++; $display("FAIL reset_w4 got %h exp 0", {ov4, s4, co4, of4, g4, p4});
    end
    tests++;
    if ({ov8, s8, co8, of8, g8, p8} !== 27'b0) begin
      fails++; $display("FAIL reset_w8 got %h exp 0", {ov8, s8, co8, of8, g8, p8});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // HA/FA truth tables through the WIDTH=1 instance, back to back.
  task automatic test_cells_w1();
    bit [1:0] ab    [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
    bit       es0   [4] = '{0, 1, 1, 0};
    bit       ec0   [4] = '{0, 0, 0, 1};
    bit       es1   [4] = '{1, 0, 0, 1};
    bit       ec1   [4] = '{0, 1, 1, 1};
    bit       eo1   [4] = '{1, 0, 0, 0};
    bit       eg    [4] = '{0, 0, 0, 1};
    bit       ep    [4] = '{0, 1, 1, 0};
    bit es, ec, eo;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        v1 = 1; a1 = ab[i][1]; b1 = ab[i][0]; ci1 = c[0];
        es = c[0] ? es1[i] : es0[i];
        ec = c[0] ? ec1[i] : ec0[i];
        eo = c[0] ? eo1[i] : ec0[i];
        @(posedge clk); #1;
        tests++;
        if ({ov1, s1, co1, of1, g1, p1} !== {1'b1, es, ec, eo, eg[i], ep[i]}) begin
          fails++;
          $display("FAIL cell_w1 cin=%0d ab=%b got v,s,co,ovf,g,p=%b exp %b", c, ab[i],
                   {ov1, s1, co1, of1, g1, p1}, {1'b1, es, ec, eo, eg[i], ep[i]});
        end
      end
    end
    @(negedge clk);
    v1 = 0;
  endtask

  task automatic test_arith_w4();
    logic [3:0] ta [4] = '{4'hF, 4'h7, 4'hF, 4'h8};
    logic [3:0] tb [4] = '{4'h1, 4'h1, 4'hF, 4'h8};
    logic       tc [4] = '{0, 0, 1, 0};
    logic [3:0] xs [4] = '{4'h0, 4'h8, 4'hF, 4'h0};
    logic       xc [4] = '{1, 0, 1, 1};
    logic       xo [4] = '{0, 1, 0, 1};
    logic [3:0] xg [4] = '{4'h1, 4'h1, 4'hF, 4'h8};
    logic [3:0] xp [4] = '{4'hE, 4'h6, 4'h0, 4'h0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      v4 = 1; a4 = ta[i]; b4 = tb[i]; ci4 = tc[i];
      @(posedge clk); #1;
      tests++;
      if ({ov4, s4, co4, of4, g4, p4} !== {1'b1, xs[i], xc[i], xo[i], xg[i], xp[i]}) begin
        fails++;
        $display("FAIL arith_w4 #%0d got v=%b s=%h co=%b ovf=%b g=%h p=%h exp s=%h co=%b ovf=%b g=%h p=%h",
                 i, ov4, s4, co4, of4, g4, p4, xs[i], xc[i], xo[i], xg[i], xp[i]);
      end
    end
    @(negedge clk);
    v4 = 0;
  endtask

  task automatic load_3_4();
    @(negedge clk);
    v4 = 1; a4 = 4'h3; b4 = 4'h4; ci4 = 0;
    @(posedge clk); #1;
    tests++;
    if ({ov4, s4, co4, of4, g4, p4} !== {1'b1, 4'h7, 1'b0, 1'b0, 4'h0, 4'h7}) begin
      fails++; $display("FAIL load_3_4 got v=%b s=%h co=%b ovf=%b g=%h p=%h exp v=1 s=7 co=0 ovf=0 g=0 p=7",
                        ov4, s4, co4, of4, g4, p4);
    end
  endtask

  task automatic test_hold();
    load_3_4();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      v4 = 0; a4 = (i == 1) ? 4'bxxxx : 4'(i * 5 + 9); b4 = 4'(i + 10); ci4 = (i == 2) ? 1'bx : 1'b1;
      @(posedge clk); #1;
      tests++;
      if ({ov4, s4, co4, of4, g4, p4} !== {1'b0, 4'h7, 1'b0, 1'b0, 4'h0, 4'h7}) begin
        fails++; $display("FAIL hold #%0d got v=%b s=%h co=%b ovf=%b g=%h p=%h exp v=0 s=7 co=0 ovf=0 g=0 p=7",
                          i, ov4, s4, co4, of4, g4, p4);
      end
    end
    a4 = 0; b4 = 0; ci4 = 0;
  endtask

  task automatic test_async_reset();
    load_3_4();
    v4 = 0;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({ov4, s4, co4, of4, g4, p4} !== 15'b0) begin
      fails++; $display("FAIL async_reset got %h exp 0", {ov4, s4, co4, of4, g4, p4});
    end
    @(negedge clk);
    rst_n = 1'b1;
    v4 = 1; a4 = 4'h2; b4 = 4'h2; ci4 = 0;
    @(posedge clk); #1;
    tests++;
    if ({ov4, s4, co4, of4} !== {1'b1, 4'h4, 1'b0, 1'b0}) begin
      fails++; $display("FAIL post_reset got v=%b s=%h co=%b ovf=%b exp v=1 s=4 co=0 ovf=0",
                        ov4, s4, co4, of4);
    end
    @(negedge clk);
    v4 = 0;
  endtask

  // WIDTH=8 stream with random in_valid against an arithmetic reference.
  task automatic test_back_to_back_w8();
    logic       ev = 0, ec = 0, eo = 0;
    logic [7:0] es = 0, eg = 0, ep = 0;
    logic [8:0] full;
    int         bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      v8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
      if (i < 3) begin v8 = 1; a8 = 8'hFF; b8 = 8'hFF; ci8 = (i != 1); end
      ev = v8;
      if (v8) begin
        full = {1'b0, a8} + {1'b0, b8} + {8'b0, ci8};
        es = full[7:0];
        ec = full[8];
        eo = (a8[7] == b8[7]) && (full[7] != a8[7]);
        eg = a8 & b8;
        ep = a8 ^ b8;
      end
      @(posedge clk); #1;
      tests++;
      if ({ov8, s8, co8, of8, g8, p8} !== {ev, es, ec, eo, eg, ep}) begin
        fails++;
        if (bad++ < 10)
          $display("FAIL stream_w8 #%0d got v=%b s=%h co=%b ovf=%b g=%h p=%h exp v=%b s=%h co=%b ovf=%b g=%h p=%h",
                   i, ov8, s8, co8, of8, g8, p8, ev, es, ec, eo, eg, ep);
      end
    end
    @(negedge clk);
    v8 = 0;
  endtask

  initial begin
    test_reset();
    test_cells_w1();
    test_arith_w4();
    test_hold();
    test_async_reset();
    test_back_to_back_w8();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
